// File: rtl/efuse_cfg_loader.sv
// Boot-time eFuse reader: fetches bytes over Wishbone and
// shifts them MSB-first into the fabric config chain.
module efuse_cfg_loader #(
  parameter int unsigned NUM_BYTES = 256,
  parameter logic [10:0] BASE_ADDR = 11'd0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic        wb_sel_o,
  output logic [10:0] wb_adr_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  output logic        cfg_data_o,
  output logic        cfg_shift_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [11:0] IDX_LAST = 12'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SHIFT,
    S_DONE,
    S_ERR
  } state_e;

  state_e          state_q;
  logic [11:0]     idx_q;
  logic [TW-1:0]   tmo_q;
  logic [2:0]      bit_q;
  logic [6:0]      sr_q;
  logic            bus_q;
  logic [10:0]     adr_q;
  logic            sdat_q;
  logic            shift_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  // Loader FSM with all outputs registered; reset drops bus and shift at once.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      bus_q   <= 1'b0;
      adr_q   <= '0;
      sdat_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_q <= S_REQ;
            idx_q   <= '0;
            tmo_q   <= '0;
            bus_q   <= 1'b1;
            adr_q   <= BASE_ADDR;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        S_REQ: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (wb_ack_i) begin
            state_q <= S_SHIFT;
            bus_q   <= 1'b0;
            sr_q    <= wb_dat_i[6:0];
            sdat_q  <= wb_dat_i[7];
            shift_q <= 1'b1;
            bit_q   <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_ERR;
            bus_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_SHIFT: begin
          if (bit_q == 3'd7) begin
            shift_q <= 1'b0;
            sdat_q  <= 1'b0;
            if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_REQ;
              idx_q   <= idx_q + 12'd1;
              tmo_q   <= '0;
              bus_q   <= 1'b1;
              adr_q   <= adr_q + 11'd1;
            end
          end else begin
            bit_q  <= bit_q + 3'd1;
            sdat_q <= sr_q[6];
            sr_q   <= {sr_q[5:0], 1'b0};
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_cyc_o    = bus_q;
  assign wb_stb_o    = bus_q;
  assign wb_we_o     = 1'b0;
  assign wb_sel_o    = 1'b1;
  assign wb_adr_o    = adr_q;
  assign cfg_data_o  = sdat_q;
  assign cfg_shift_o = shift_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = err_q;

endmodule
